aes_byte_stream_bridge: RTL and testbench
=========================================

# aes_byte_stream_bridge

Parametrised byte-stream front/back end for the pipelined AES encryption core. Packs incoming UART-side bytes into BLOCK_W-bit blocks and issues them to a non-stallable AES pipeline of fixed latency LAT. Buffers returning ciphertext in an OUT_DEPTH-block FIFO and serialises it back to bytes under valid/ready backpressure. A credit scheme guarantees no ciphertext is ever dropped.

## Interface
- BLOCK_W, default 128: block width in bits; multiple of 8; NB = BLOCK_W/8 bytes per block.
- LAT, default 10: AES core latency in cycles from core_in_valid to core_out_valid; ≥1.
- OUT_DEPTH, default 4: output FIFO depth in blocks; power of 2, ≥2.

- clk  in  1  system clock; all logic on rising edge.
- rs_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  plaintext byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- abort  in  1  synchronous; discards the partially packed block.
- core_in_valid  out  1  one-cycle issue pulse to the AES core.
- core_in_data  out  BLOCK_W  plaintext block to the core.
- core_out_valid  in  1  ciphertext valid from the core (cannot be stalled).
- core_out_data  in  BLOCK_W  ciphertext block.
- out_byte  out  8  ciphertext byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready.
- busy  out  1  any block is in progress anywhere in the bridge.
- err  out  1  sticky overflow flag.

## Operation
- Packer: byte counter 0..NB-1. The first byte of a block goes to bits [BLOCK_W-1 -: 8], then MSB-first downward.
  - On accepting byte NB-1, the block moves to the pending register (pend_full=1) and the counter wraps to 0.
- in_ready = !pend_full && !abort.
  - abort with in_valid in the same cycle: abort wins and the byte is dropped.
  - abort clears the counter and partial data only. It does not touch pend, in-flight blocks, the FIFO or the serialiser.
- Issue: core_in_valid = pend_full && credit>0, where credit = OUT_DEPTH − fifo_count − inflight.
  - On issue, pend clears on the same edge.
  - core_in_data is the pend register, held stable.
- inflight counter: +1 on issue, −1 on core_out_valid. Both in the same cycle leaves it unchanged. Width is clog2(OUT_DEPTH+1).
- FIFO writes core_out_data on core_out_valid.
  - If the FIFO is full and not popping in that cycle: the write is dropped, err←1 (sticky until reset), and FIFO contents are unchanged.
- Serialiser: when ser_full=0 and the FIFO is non-empty, pop the head into the shift register and set ser_full=1.
  - out_byte = bits [BLOCK_W-1 -: 8]; out_valid = ser_full.
  - On each handshake, shift left by 8.
  - After handshake NB, ser_full clears. A reload can happen the next cycle at the earliest.
- busy = pend_full | byte_cnt≠0 | inflight≠0 | fifo non-empty | ser_full.
- Reset (any time, asynchronous): all counters, pend, FIFO pointers, serialiser and err cleared.
  - All outputs 0 except in_ready, which is 1 after reset is released.
  - core_in_data resets to 0.
  - The core shares rs_n, so no stale core_out_valid follows reset.

## Timing
- Last byte of a block accepted at cycle t:
  - pend_full during t+1; core_in_valid during t+1 if credit>0.
  - core_out_valid at t+1+LAT; FIFO non-empty at t+2+LAT.
  - First out_valid at t+3+LAT with the serialiser idle.
- in_ready is low for exactly one cycle per block when credit is available: NB+1 cycles per block on input.
- Output rate: NB bytes per NB+1 cycles when out_ready is held high.
- The serialiser is not counted in credit. Maximum blocks held downstream = OUT_DEPTH + 1.

## Structure
- Package aes_stream_pkg: BYTE_W=8 constant, function nbytes(BLOCK_W), typedef for the byte type.
- Sub-module aes_blk_fifo: parametrised width/depth synchronous FIFO with count output, same clk/rs_n.
- Packer, credit logic and serialiser stay in the top.

## Test plan
- Single block, LAT=10 identity-delay core model, bytes 00..0F, out_ready=1.
  - Expect core_in_data=000102…0F and out_byte sequence 00..0F.
  - Expect first out_valid 13 cycles after the last byte is accepted; busy falls after byte 0F.
- Backpressure, out_ready=0, feed 6 blocks, OUT_DEPTH=4.
  - Expect exactly 5 core_in_valid pulses, pend held, in_ready=0, 97th byte not accepted, err=0.
  - Then out_ready=1: expect all 96 bytes drained in order.
- abort after 7 bytes, then bytes 10..1F.
  - Expect a single issue with core_in_data=101112…1F.
  - abort asserted together with in_valid drops that byte.
- Continuous streaming of 8 blocks, out_ready=1.
  - Expect in_ready low exactly one cycle per block.
  - Expect cycles with simultaneous issue and core_out_valid to leave inflight unchanged, and correct ordering.
- Forced core_out_valid with the FIFO full and out_ready=0.
  - Expect err=1 sticky, FIFO contents unchanged, err cleared only by rs_n.
- Reset asserted with 2 blocks in flight and the serialiser mid-block.
  - Expect out_valid, core_in_valid, busy and err to drop immediately.
  - After release: in_ready=1, and the next block is processed normally.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared constants, types and sizing helpers for the AES byte-stream bridge.
package aes_stream_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Number of bytes in one block of the given width.
  function automatic int nbytes(input int block_w);
    return block_w / BYTE_W;
  endfunction

  // Counter width able to index n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block-wide synchronous FIFO with an occupancy count. A write into a full
// FIFO is ignored unless a read frees a slot in the same cycle.
module aes_blk_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rs_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  // Pointer and occupancy update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CW'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rs_n) begin
    // NOTE: asynchronous active-low reset; state must clear without a running clock.
    if (!rs_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the cleared count marks every entry invalid.
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/aes_byte_stream_bridge.sv
// Byte-stream front/back end for a fixed-latency, non-stallable AES pipeline:
// packs bytes into blocks, issues them under a credit limit that guarantees
// room for every returning block, and serialises ciphertext back to bytes.
module aes_byte_stream_bridge
  import aes_stream_pkg::*;
#(
  parameter int BLOCK_W   = 128,
  parameter int LAT       = 10,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rs_n,
  input  logic [BYTE_W-1:0]  in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic               core_in_valid,
  output logic [BLOCK_W-1:0] core_in_data,
  input  logic               core_out_valid,
  input  logic [BLOCK_W-1:0] core_out_data,
  output logic [BYTE_W-1:0]  out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  localparam int NB    = nbytes(BLOCK_W);
  localparam int CNT_W = cnt_w(NB);
  localparam int CW    = $clog2(OUT_DEPTH + 1);

  // Elaboration-time parameter sanity checks.
  if (BLOCK_W < BYTE_W || (BLOCK_W % BYTE_W) != 0) begin : g_bad_block_w
    $error("BLOCK_W must be a non-zero multiple of 8");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("LAT must be at least 1");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("OUT_DEPTH must be a power of two, at least 2");
  end

  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BLOCK_W-1:0] pack_q, pack_d;
  logic [BLOCK_W-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [BLOCK_W-1:0] ser_q, ser_d;
  logic [CNT_W-1:0]   ser_cnt_q, ser_cnt_d;
  logic               ser_full_q, ser_full_d;
  logic               err_q, err_d;

  logic [BLOCK_W-1:0] fifo_rd_data;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic               in_fire, issue, pop, out_fire, overflow;

  // Blocks that will land in the FIFO (queued plus in the pipeline) must
  // never exceed its depth; the serialiser holds one extra block on top.
  assign issue    = pend_full_q && ((int'(fifo_count) + int'(inflight_q)) < OUT_DEPTH);
  assign in_ready = !pend_full_q && !abort;
  assign in_fire  = in_valid && in_ready;
  assign pop      = !ser_full_q && !fifo_empty;
  assign out_fire = ser_full_q && out_ready;
  assign overflow = core_out_valid && fifo_full && !pop;

  assign core_in_valid = issue;
  assign core_in_data  = pend_q;
  assign out_byte      = ser_q[BLOCK_W-1 -: BYTE_W];
  assign out_valid     = ser_full_q;
  assign err           = err_q;
  assign busy          = pend_full_q | (byte_cnt_q != '0) | (inflight_q != '0)
                       | !fifo_empty | ser_full_q;

  aes_blk_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rs_n    (rs_n),
    .wr_en   (core_out_valid),
    .wr_data (core_out_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Packer, pending register, in-flight credit and sticky overflow flag.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    inflight_d  = inflight_q;
    err_d       = err_q | overflow;

    if (abort) begin
      byte_cnt_d = '0;
      pack_d     = '0;
    end else if (in_fire) begin
      // Bytes fill MSB-first; unfilled positions are still zero, so OR-in.
      pack_d = pack_q | (BLOCK_W'(in_byte) << (BLOCK_W - BYTE_W * (int'(byte_cnt_q) + 1)));
      if (byte_cnt_q == CNT_W'(NB - 1)) begin
        pend_d      = pack_d;
        pend_full_d = 1'b1;
        pack_d      = '0;
        byte_cnt_d  = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end

    if (issue) pend_full_d = 1'b0;

    // A stray return with nothing in flight must not wrap the counter.
    if (issue && !core_out_valid)                         inflight_d = inflight_q + CW'(1);
    else if (!issue && core_out_valid && inflight_q != '0) inflight_d = inflight_q - CW'(1);
  end

  // Serialiser: load from the FIFO when idle, shift one byte per handshake.
  always_comb begin
    ser_d      = ser_q;
    ser_cnt_d  = ser_cnt_q;
    ser_full_d = ser_full_q;
    if (pop) begin
      ser_d      = fifo_rd_data;
      ser_cnt_d  = '0;
      ser_full_d = 1'b1;
    end else if (out_fire) begin
      ser_d = ser_q << BYTE_W;
      if (ser_cnt_q == CNT_W'(NB - 1)) begin
        ser_cnt_d  = '0;
        ser_full_d = 1'b0;
      end else begin
        ser_cnt_d = ser_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      inflight_q  <= '0;
      ser_q       <= '0;
      ser_cnt_q   <= '0;
      ser_full_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      inflight_q  <= inflight_d;
      ser_q       <= ser_d;
      ser_cnt_q   <= ser_cnt_d;
      ser_full_q  <= ser_full_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_byte_stream_bridge.sv
// Self-checking bench for aes_byte_stream_bridge: a 128-bit instance for the
// directed scenarios and a 32-bit instance for continuous streaming, each with
// an identity-delay core model of latency LAT.
module tb_aes_byte_stream_bridge;

  localparam int BW    = 128;
  localparam int NB    = 16;
  localparam int SBW   = 32;
  localparam int LAT   = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rs_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 128-bit instance ----------------
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic          in_ready, civ, cov, out_valid, busy, err;
  logic [BW-1:0] cid, cod;
  logic [7:0]    out_byte;
  logic          force_cov = 1'b0;
  logic [BW-1:0] force_data = '0;
  logic [LAT-1:0] vpipe;
  logic [BW-1:0]  dpipe [LAT];

  aes_byte_stream_bridge #(.BLOCK_W(BW), .LAT(LAT), .OUT_DEPTH(DEPTH)) u_big (
    .clk(clk), .rs_n(rs_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .core_in_valid(civ), .core_in_data(cid), .core_out_valid(cov),
    .core_out_data(cod), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err));

  always @(posedge clk or negedge rs_n)
    if (!rs_n) vpipe <= '0;
    else       vpipe <= {vpipe[LAT-2:0], civ};
  always @(posedge clk) begin
    dpipe[0] <= cid;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign cov = vpipe[LAT-1] | force_cov;
  assign cod = force_cov ? force_data : dpipe[LAT-1];

  // ---------------- 32-bit instance ----------------
  logic [7:0]     s_in_byte = '0;
  logic           s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic           s_in_ready, s_civ, s_cov, s_out_valid, s_busy, s_err;
  logic [SBW-1:0] s_cid, s_cod;
  logic [7:0]     s_out_byte;
  logic [LAT-1:0] s_vpipe;
  logic [SBW-1:0] s_dpipe [LAT];

  aes_byte_stream_bridge #(.BLOCK_W(SBW), .LAT(LAT), .OUT_DEPTH(DEPTH)) u_small (
    .clk(clk), .rs_n(rs_n), .in_byte(s_in_byte), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .abort(1'b0), .core_in_valid(s_civ), .core_in_data(s_cid), .core_out_valid(s_cov),
    .core_out_data(s_cod), .out_byte(s_out_byte), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .busy(s_busy), .err(s_err));

  always @(posedge clk or negedge rs_n)
    if (!rs_n) s_vpipe <= '0;
    else       s_vpipe <= {s_vpipe[LAT-2:0], s_civ};
  always @(posedge clk) begin
    s_dpipe[0] <= s_cid;
    for (int i = 1; i < LAT; i++) s_dpipe[i] <= s_dpipe[i-1];
  end
  assign s_cov = s_vpipe[LAT-1];
  assign s_cod = s_dpipe[LAT-1];

  // ---------------- monitors ----------------
  int civ_cnt = 0;
  int s_overlap = 0;
  always @(negedge clk) begin
    if (civ) civ_cnt <= civ_cnt + 1;
    if (s_civ && s_cov) s_overlap <= s_overlap + 1;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic reset_all();
    rs_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted; returns the accepting cycle.
  task automatic send_byte(input logic [7:0] b, output int t_acc);
    int budget;
    budget = 200;
    t_acc = -1;
    in_byte = b;
    in_valid = 1'b1;
    while (budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        t_acc = cyc;
        break;
      end
      budget--;
    end
    if (t_acc < 0) fail_timeout("send_byte");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base, output int t_last);
    for (int i = 0; i < NB; i++) send_byte(8'(base + 8'(i)), t_last);
  endtask

  logic [7:0] got_q[$];
  int first_out_cyc;

  task automatic collect(input int n, input int budget);
    got_q.delete();
    first_out_cyc = -1;
    while (got_q.size() < n && budget > 0) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        got_q.push_back(out_byte);
      end
      budget--;
    end
    if (got_q.size() < n) fail_timeout("collect");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]   base;
    logic [127:0] exp_block;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] s_got[$];
  int s_lows, s_fed;
  logic s_last_low;

  initial begin
    int t_last, base_civ, nerr, acc, cnt;
    logic [127:0] blk;

    vecs[0] = '{8'h00, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{8'hf0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff};
    vecs[2] = '{8'h80, 128'h808182838485868788898a8b8c8d8e8f};
    vecs[3] = '{8'hf8, 128'hf8f9fafbfcfdfeff0001020304050607};

    // ---- reset state ----
    reset_all();
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_civ",       civ,       1'b0);
    check("rst_cid",       cid,       128'h0);
    check("rst_busy",      busy,      1'b0);
    check("rst_err",       err,       1'b0);
    @(posedge clk);
    #1;

    // ---- single blocks from the table, out_ready held high ----
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      base_civ = civ_cnt;
      send_block(vecs[v].base, t_last);
      @(negedge clk);
      check("blk_civ",      civ,      1'b1);
      check("blk_cid",      cid,      vecs[v].exp_block);
      check("blk_in_ready", in_ready, 1'b0);
      collect(NB, 100);
      check("blk_out_latency", first_out_cyc - t_last, 13);
      nerr = 0;
      for (int i = 0; i < NB; i++) begin
        blk = vecs[v].exp_block;
        if (got_q[i] !== blk[127 - 8*i -: 8]) nerr++;
      end
      check("blk_out_bytes", nerr, 0);
      check("blk_busy_last", busy, 1'b1);
      @(negedge clk);
      check("blk_busy_idle", busy, 1'b0);
      check("blk_issue_cnt", civ_cnt - base_civ, 1);
      @(posedge clk);
      #1;
    end

    // ---- backpressure: 6 blocks with out_ready low ----
    reset_all();
    out_ready = 1'b0;
    base_civ = civ_cnt;
    for (int i = 0; i < 6 * NB; i++) send_byte(8'(i), t_last);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_issue_cnt", civ_cnt - base_civ, 5);
    check("bp_in_ready",  in_ready, 1'b0);
    check("bp_civ_held",  civ,      1'b0);
    check("bp_pend_data", cid,      128'h505152535455565758595a5b5c5d5e5f);
    check("bp_err",       err,      1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    in_byte = 8'haa;
    in_valid = 1'b1;
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) acc++;
    end
    check("bp_byte97_refused", acc, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // ---- forced return into the full FIFO ----
    force_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    force_cov = 1'b1;
    @(posedge clk);
    #1;
    force_cov = 1'b0;
    @(negedge clk);
    check("ovf_err_set", err, 1'b1);
    repeat (5) @(negedge clk);
    check("ovf_err_sticky", err, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    collect(6 * NB, 600);
    nerr = 0;
    for (int i = 0; i < 6 * NB; i++) if (got_q[i] !== 8'(i)) nerr++;
    check("bp_drain_order", nerr, 0);
    check("bp_issue_total", civ_cnt - base_civ, 6);
    @(negedge clk);
    check("ovf_err_after_drain", err, 1'b1);
    check("bp_busy_idle", busy, 1'b0);
    #2;
    rs_n = 1'b0;
    #1;
    check("ovf_err_reset", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- abort ----
    out_ready = 1'b1;
    base_civ = civ_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'(8'ha0 + 8'(i)), t_last);
    @(negedge clk);
    check("abort_busy_partial", busy, 1'b1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hee;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_clear", busy, 1'b0);
    @(posedge clk);
    #1;
    send_block(8'h10, t_last);
    @(negedge clk);
    check("abort_civ", civ, 1'b1);
    check("abort_cid", cid, 128'h101112131415161718191a1b1c1d1e1f);
    collect(NB, 100);
    nerr = 0;
    for (int i = 0; i < NB; i++) if (got_q[i] !== 8'(8'h10 + 8'(i))) nerr++;
    check("abort_out_bytes", nerr, 0);
    check("abort_issue_cnt", civ_cnt - base_civ, 1);
    @(posedge clk);
    #1;

    // ---- continuous streaming on the 32-bit instance ----
    s_lows = 0;
    s_fed = 0;
    s_got.delete();
    fork
      begin
        int n, bud;
        n = 0;
        bud = 400;
        s_in_byte = 8'h40;
        s_in_valid = 1'b1;
        while (n < 32 && bud > 0) begin
          @(negedge clk);
          if (s_in_ready) n++;
          else s_lows++;
          bud--;
          @(posedge clk);
          #1;
          s_in_byte = 8'(8'h40 + 8'(n));
        end
        s_in_valid = 1'b0;
        s_fed = n;
        @(negedge clk);
        s_last_low = !s_in_ready;
      end
      begin
        int bud;
        bud = 600;
        while (s_got.size() < 32 && bud > 0) begin
          @(negedge clk);
          if (s_out_valid && s_out_ready) s_got.push_back(s_out_byte);
          bud--;
        end
      end
    join
    if (s_got.size() < 32) fail_timeout("stream_collect");
    check("stream_fed", s_fed, 32);
    check("stream_ready_lows", s_lows, 7);
    check("stream_last_pend_low", s_last_low, 1'b1);
    nerr = 0;
    for (int i = 0; i < 32; i++) if (s_got[i] !== 8'(8'h40 + 8'(i))) nerr++;
    check("stream_order", nerr, 0);
    check("stream_overlap_seen", s_overlap > 0, 1'b1);
    @(negedge clk);
    check("stream_busy_idle", s_busy, 1'b0);
    check("stream_err", s_err, 1'b0);
    @(posedge clk);
    #1;

    // ---- reset with blocks downstream and the serialiser mid-block ----
    reset_all();
    out_ready = 1'b0;
    send_block(8'h20, t_last);
    repeat (16) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_block(8'h30, t_last);
    repeat (14) @(posedge clk);
    #1;
    send_block(8'h60, t_last);
    @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1'b1);
    check("mid_out_valid_before", out_valid, 1'b1);
    #2;
    rs_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_civ", civ, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("mid_no_stale_out", cnt, 0);
    @(posedge clk);
    #1;
    base_civ = civ_cnt;
    send_block(8'h50, t_last);
    collect(NB, 100);
    check("mid_post_latency", first_out_cyc - t_last, 13);
    nerr = 0;
    for (int i = 0; i < NB; i++) if (got_q[i] !== 8'(8'h50 + 8'(i))) nerr++;
    check("mid_post_bytes", nerr, 0);
    check("mid_post_issue_cnt", civ_cnt - base_civ, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
